rtc_bus_scheduler: RTL and testbench
====================================

# rtc_bus_scheduler

Sequencer and arbiter for the multiplexed address/data RTC bus (AD, a_d, cs, rd, wr). It accepts one-cycle request pulses from the PicoBlaze output register bank and turns each into a fixed sequence of RTC register accesses. The requests are init, stop ring, write timer, write time, write date and read-all. Requests are arbitrated by fixed priority, and the block generates every bus phase itself. Read bytes are returned to the input register bank, and a one-cycle `ready` pulse is sent to the Pico when each sequence finishes.

## Interface
Parameters:
- T_PHASE, 10, clk cycles per bus phase (≥1)
- AUTO_PERIOD, 2000000, clk cycles between automatic reads (only with RTC_AUTO_READ_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- req_init, req_stop_ring, req_timer, req_hora, req_fecha, req_read  in  1 each  one-cycle request pulses
- wr_sel  out  4  selects the write value: 0 thora, 1 tmin, 2 tseg, 3 anio, 4 mes, 5 dia, 6 hora, 7 min, 8 seg
- wr_data  in  8  value selected by wr_sel, combinational from the output register bank
- ad_in  in  8  AD bus sampled value
- ad_out  out  8  value driven onto AD
- ad_oe  out  1  1 = tristate buffer drives AD
- a_d, cs, rd, wr  out  1 each  RTC strobes, active-low except a_d (0 = address phase)
- rd_data  out  8  byte read from the RTC
- rd_idx  out  4  index of the byte read, same encoding as wr_sel
- rd_valid  out  1  one-cycle pulse, rd_data/rd_idx valid
- busy  out  1  sequence in progress
- ready  out  1  one-cycle pulse at the end of each sequence

## Operation
- Pending bits:
  - Each request pulse sets its pending bit.
  - The bit clears in the cycle its sequence is granted.
  - A pulse arriving while the same sequence runs sets the bit again, so that sequence runs once more afterwards.
- Priority when idle: init > stop_ring > timer > hora > fecha > read > auto-read. There is no preemption.
- Sequences, written as address←data:
  - init: 0x02←0x10, 0x02←0x00, 0x00←0x00, 0x01←0xD0
  - stop_ring: 0x00←0x00
  - timer: 0x41←tseg, 0x42←tmin, 0x43←thora, 0xF2←0xF2
  - hora: 0x21←seg, 0x22←min, 0x23←hora, 0xF1←0xF1
  - fecha: 0x24←dia, 0x25←mes, 0x26←anio, 0xF1←0xF1
  - read: 0xF0←0xF0, then reads 0x21 seg, 0x22 min, 0x23 hora, 0x24 dia, 0x25 mes, 0x26 anio, 0x41 tseg, 0x42 tmin, 0x43 thora
- Top-level states: IDLE → ACCESS (repeated once per sequence step) → DONE → IDLE.
- Each access has 8 phases of T_PHASE cycles:
  1. A_SET: cs=0, a_d=0, ad_oe=1, ad_out=addr
  2. A_STB: additionally wr=0
  3. A_HLD: wr=1
  4. GAP1: cs=1, ad_oe=0
  5. D_SET: cs=0, a_d=1; for writes ad_oe=1 and ad_out=data
  6. D_STB: wr=0 for a write, rd=0 for a read
  7. D_HLD: strobes high
  8. GAP2: cs=1, a_d=1, ad_oe=0
- wr_sel is held for the whole access. wr_data is registered on entry to D_SET.
- Reads: ad_in is captured on the last cycle of D_STB. rd_valid pulses on the next cycle, together with rd_data and rd_idx.
- Reset values: a_d=cs=rd=wr=1, ad_oe=0, ad_out=0, wr_sel=0, rd_data=0, rd_idx=0, rd_valid=0, busy=0, ready=0, all pending bits cleared, phase counter 0.

## Timing
- Request pulse at cycle n: pending bit set at n+1, grant and A_SET (cs falls) at n+2.
- Access length is 8·T_PHASE cycles; a sequence of N accesses takes N·8·T_PHASE cycles.
- DONE is one cycle: ready=1, busy=0. The earliest next A_SET is the following cycle.
- busy is 1 from grant through the last cycle of the final GAP2.
- Simultaneous requests: every pulse is latched. They are served in priority order, back to back, with one ready pulse per sequence.
- The phase counter counts 0..T_PHASE−1 and then advances the phase. With T_PHASE=1 every phase lasts exactly one cycle.
- Reset asserted mid-access: all outputs return to their reset values immediately (asynchronously), and the partial access is abandoned. After release the block is IDLE and no requests are pending.

## Configuration
- RTC_AUTO_READ_EN defined:
  - A free-running counter raises an internal read request every AUTO_PERIOD cycles, starting after reset release.
  - The request has the lowest priority.
  - It does not merge with a pending req_read; both run.
  - Its read sequence also produces rd_valid pulses and a ready pulse.
- RTC_AUTO_READ_EN undefined: no counter is built, AUTO_PERIOD is unused, and reads happen only on req_read.

## Test plan
- Reset, with T_PHASE=2: all outputs at their reset values, and no bus activity for 100 cycles.
- req_hora with wr_data values seg=0x45, min=0x30, hora=0x12: four accesses to 0x21/0x22/0x23/0xF1 carrying 0x45/0x30/0x12/0xF1. Each access is 16 cycles with wr low for 2 cycles in A_STB and 2 in D_STB. One ready pulse at cycle 66 after the request.
- req_read against an RTC model returning addr+1: nine rd_valid pulses, with rd_idx 8,7,6,5,4,3,2,1,0 and rd_data 0x22..0x27, 0x42..0x44. rd is never low together with ad_oe=1.
- req_fecha and req_stop_ring in the same cycle: stop_ring (1 access) runs first, then fecha (4 accesses). Two ready pulses.
- rst low during D_STB of a timer write: cs/wr high and ad_oe=0 in the same cycle. After release, busy=0 and no sequence resumes.
- With RTC_AUTO_READ_EN and AUTO_PERIOD=500: read sequences start every 500 cycles. A req_timer arriving during an auto read runs immediately after it finishes.

Source files
------------

// File: rtl/rtc_bus_scheduler.sv
// rtc_bus_scheduler: sequencer/arbiter for the multiplexed AD RTC bus.
// Latches one-cycle requests, picks one by fixed priority and plays its
// fixed list of register accesses, each split into 8 bus phases of
// T_PHASE clocks. Read bytes are returned with a one-cycle rd_valid pulse.
// Optional feature macro: RTC_AUTO_READ_EN (periodic automatic read-all).
module rtc_bus_scheduler #(
    parameter int T_PHASE     = 10,
    parameter int AUTO_PERIOD = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_init,
    input  logic       req_stop_ring,
    input  logic       req_timer,
    input  logic       req_hora,
    input  logic       req_fecha,
    input  logic       req_read,
    output logic [3:0] wr_sel,
    input  logic [7:0] wr_data,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       a_d,
    output logic       cs,
    output logic       rd,
    output logic       wr,
    output logic [7:0] rd_data,
    output logic [3:0] rd_idx,
    output logic       rd_valid,
    output logic       busy,
    output logic       ready
);

    localparam int            CW      = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(T_PHASE - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;
    typedef enum logic [2:0] {
        PH_A_SET, PH_A_STB, PH_A_HLD, PH_GAP1,
        PH_D_SET, PH_D_STB, PH_D_HLD, PH_GAP2
    } phase_e;
    typedef enum logic [2:0] {SQ_INIT, SQ_STOP, SQ_TIMER, SQ_HORA, SQ_FECHA, SQ_READ} seq_e;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;     // constant write data when use_sel=0
        logic [3:0] sel;      // wr_sel for writes, rd_idx for reads
        logic       use_sel;  // write data comes from wr_data
        logic       is_read;
        logic       last;
    } step_t;

    // Sequence tables: one entry per register access.
    function automatic step_t step_info(input seq_e seq, input logic [3:0] step);
        step_t s;
        s = '0;
        case (seq)
            SQ_INIT: begin
                case (step)
                    4'd0:    begin s.addr = 8'h02; s.data = 8'h10; end
                    4'd1:    begin s.addr = 8'h02; s.data = 8'h00; end
                    4'd2:    begin s.addr = 8'h00; s.data = 8'h00; end
                    default: begin s.addr = 8'h01; s.data = 8'hD0; s.last = 1'b1; end
                endcase
            end
            SQ_STOP: begin
                s.addr = 8'h00; s.data = 8'h00; s.last = 1'b1;
            end
            SQ_TIMER: begin
                case (step)
                    4'd0:    begin s.addr = 8'h41; s.sel = 4'd2; s.use_sel = 1'b1; end
                    4'd1:    begin s.addr = 8'h42; s.sel = 4'd1; s.use_sel = 1'b1; end
                    4'd2:    begin s.addr = 8'h43; s.sel = 4'd0; s.use_sel = 1'b1; end
                    default: begin s.addr = 8'hF2; s.data = 8'hF2; s.last = 1'b1; end
                endcase
            end
            SQ_HORA: begin
                case (step)
                    4'd0:    begin s.addr = 8'h21; s.sel = 4'd8; s.use_sel = 1'b1; end
                    4'd1:    begin s.addr = 8'h22; s.sel = 4'd7; s.use_sel = 1'b1; end
                    4'd2:    begin s.addr = 8'h23; s.sel = 4'd6; s.use_sel = 1'b1; end
                    default: begin s.addr = 8'hF1; s.data = 8'hF1; s.last = 1'b1; end
                endcase
            end
            SQ_FECHA: begin
                case (step)
                    4'd0:    begin s.addr = 8'h24; s.sel = 4'd5; s.use_sel = 1'b1; end
                    4'd1:    begin s.addr = 8'h25; s.sel = 4'd4; s.use_sel = 1'b1; end
                    4'd2:    begin s.addr = 8'h26; s.sel = 4'd3; s.use_sel = 1'b1; end
                    default: begin s.addr = 8'hF1; s.data = 8'hF1; s.last = 1'b1; end
                endcase
            end
            default: begin  // SQ_READ: latch command, then nine register reads
                s.is_read = 1'b1;
                case (step)
                    4'd0:    begin s.addr = 8'hF0; s.data = 8'hF0; s.is_read = 1'b0; end
                    4'd1:    begin s.addr = 8'h21; s.sel = 4'd8; end
                    4'd2:    begin s.addr = 8'h22; s.sel = 4'd7; end
                    4'd3:    begin s.addr = 8'h23; s.sel = 4'd6; end
                    4'd4:    begin s.addr = 8'h24; s.sel = 4'd5; end
                    4'd5:    begin s.addr = 8'h25; s.sel = 4'd4; end
                    4'd6:    begin s.addr = 8'h26; s.sel = 4'd3; end
                    4'd7:    begin s.addr = 8'h41; s.sel = 4'd2; end
                    4'd8:    begin s.addr = 8'h42; s.sel = 4'd1; end
                    default: begin s.addr = 8'h43; s.sel = 4'd0; s.last = 1'b1; end
                endcase
            end
        endcase
        return s;
    endfunction

    state_e        state_q, state_d;
    phase_e        phase_q, phase_d;
    seq_e          seq_q, seq_d, gnt_seq;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    step_q, step_d;
    logic [6:0]    pend_q, pend_d, req_vec;
    logic [7:0]    data_q, data_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic [3:0]    rd_idx_q, rd_idx_d;
    logic          rd_valid_q, rd_valid_d;
    logic [2:0]    gnt_idx;
    logic          auto_req;
    step_t         cur;

`ifdef RTC_AUTO_READ_EN
    localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    logic [AW-1:0] auto_cnt_q, auto_cnt_d;

    // Free-running period counter; its wrap raises the automatic read.
    always_comb begin
        auto_req   = 1'b0;
        auto_cnt_d = auto_cnt_q + 1'b1;
        if (auto_cnt_q == AW'(AUTO_PERIOD - 1)) begin
            auto_cnt_d = '0;
            auto_req   = 1'b1;
        end
    end

    // Period counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) auto_cnt_q <= '0;
        else      auto_cnt_q <= auto_cnt_d;
    end
`else
    logic unused_auto_period;
    assign auto_req           = 1'b0;
    assign unused_auto_period = (AUTO_PERIOD != 0);
`endif

    // Bit 0 is the highest priority; the auto read has its own pending bit
    // so it never merges with a pending req_read.
    assign req_vec = {auto_req, req_read, req_fecha, req_hora, req_timer, req_stop_ring, req_init};
    assign cur     = step_info(seq_q, step_q);

    // Fixed-priority pick among the pending requests.
    always_comb begin
        gnt_idx = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (pend_q[i]) gnt_idx = 3'(i);
        end
        case (gnt_idx)
            3'd0:    gnt_seq = SQ_INIT;
            3'd1:    gnt_seq = SQ_STOP;
            3'd2:    gnt_seq = SQ_TIMER;
            3'd3:    gnt_seq = SQ_HORA;
            3'd4:    gnt_seq = SQ_FECHA;
            default: gnt_seq = SQ_READ;
        endcase
    end

    // Next state: grant from IDLE/DONE, phase/step walk during ACCESS.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        step_d     = step_q;
        seq_d      = seq_q;
        data_d     = data_q;
        pend_d     = pend_q | req_vec;
        rd_data_d  = rd_data_q;
        rd_idx_d   = rd_idx_q;
        rd_valid_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (|pend_q) begin
                    state_d = ST_ACCESS;
                    phase_d = PH_A_SET;
                    cnt_d   = '0;
                    step_d  = 4'd0;
                    seq_d   = gnt_seq;
                    // A same-cycle pulse for the granted request re-arms it.
                    pend_d[gnt_idx] = req_vec[gnt_idx];
                end
            end
            ST_ACCESS: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d   = '0;
                    phase_d = phase_e'(phase_q + 3'd1);
                    if (phase_q == PH_GAP1)
                        data_d = cur.use_sel ? wr_data : cur.data;
                    if (phase_q == PH_D_STB && cur.is_read) begin
                        rd_data_d  = ad_in;
                        rd_idx_d   = cur.sel;
                        rd_valid_d = 1'b1;
                    end
                    if (phase_q == PH_GAP2) begin
                        phase_d = PH_A_SET;
                        if (cur.last) state_d = ST_DONE;
                        else          step_d  = step_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters, pending bits and read return registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH_A_SET;
            cnt_q      <= '0;
            step_q     <= 4'd0;
            seq_q      <= SQ_INIT;
            pend_q     <= '0;
            data_q     <= 8'h00;
            rd_data_q  <= 8'h00;
            rd_idx_q   <= 4'd0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            seq_q      <= seq_d;
            pend_q     <= pend_d;
            data_q     <= data_d;
            rd_data_q  <= rd_data_d;
            rd_idx_q   <= rd_idx_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_idx   = rd_idx_q;
    assign rd_valid = rd_valid_q;

    // Bus pins decoded from registered phase; reset forces idle levels at once.
    always_comb begin
        a_d    = 1'b1;
        cs     = 1'b1;
        rd     = 1'b1;
        wr     = 1'b1;
        ad_oe  = 1'b0;
        ad_out = 8'h00;
        wr_sel = 4'd0;
        busy   = 1'b0;
        ready  = (state_q == ST_DONE);
        if (state_q == ST_ACCESS) begin
            busy   = 1'b1;
            wr_sel = cur.use_sel ? cur.sel : 4'd0;
            case (phase_q)
                PH_A_SET, PH_A_STB, PH_A_HLD: begin
                    cs     = 1'b0;
                    a_d    = 1'b0;
                    ad_oe  = 1'b1;
                    ad_out = cur.addr;
                    wr     = (phase_q != PH_A_STB);
                end
                PH_GAP1: a_d = 1'b0;
                PH_D_SET, PH_D_STB, PH_D_HLD: begin
                    cs     = 1'b0;
                    ad_oe  = !cur.is_read;
                    ad_out = cur.is_read ? 8'h00 : data_q;
                    if (phase_q == PH_D_STB) begin
                        rd = !cur.is_read;
                        wr = cur.is_read;
                    end
                end
                default: ;  // GAP2: all strobes high, bus released
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Bench for rtc_bus_scheduler (T_PHASE=2): bus accesses and read returns are
// checked against scoreboard queues filled when each request is issued.
module tb_rtc_bus_scheduler;
    localparam int TP = 2;

    logic       clk = 1'b0, rst = 1'b0;
    logic       req_init = 0, req_stop_ring = 0, req_timer = 0, req_hora = 0, req_fecha = 0, req_read = 0;
    logic [3:0] wr_sel, rd_idx;
    logic [7:0] wr_data, ad_in, ad_out, rd_data;
    logic       ad_oe, a_d, cs, rd, wr, rd_valid, busy, ready;

    rtc_bus_scheduler #(.T_PHASE(TP), .AUTO_PERIOD(500)) dut (
        .clk(clk), .rst(rst),
        .req_init(req_init), .req_stop_ring(req_stop_ring), .req_timer(req_timer),
        .req_hora(req_hora), .req_fecha(req_fecha), .req_read(req_read),
        .wr_sel(wr_sel), .wr_data(wr_data), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
        .a_d(a_d), .cs(cs), .rd(rd), .wr(wr), .rd_data(rd_data), .rd_idx(rd_idx),
        .rd_valid(rd_valid), .busy(busy), .ready(ready)
    );

    always #5 clk = ~clk;

    // Output register bank: 0 thora,1 tmin,2 tseg,3 anio,4 mes,5 dia,6 hora,7 min,8 seg
    logic [7:0] wr_vals [0:8];
    initial wr_vals = '{8'h09, 8'h08, 8'h07, 8'h24, 8'h06, 8'h15, 8'h12, 8'h30, 8'h45};
    assign wr_data = (wr_sel <= 4'd8) ? wr_vals[wr_sel] : 8'h00;

    // RTC model: a read returns the latched address plus one.
    logic [7:0] rtc_addr = 8'h00;
    always @(posedge clk) if (!cs && !a_d && ad_oe) rtc_addr <= ad_out;
    assign ad_in = rtc_addr + 8'd1;

    int nchk = 0, npass = 0, nfail = 0, cyc = 0;
    logic [31:0] exp_acc[$], exp_rd[$];
    int aset_q[$], ready_q[$];
    int ready_cnt = 0, rdv_cnt = 0, cs_low = 0, wr_bad = 0, oe_viol = 0, wr_len = 0;
    int busy_rise = -1, busy_fall = -1, req_cyc = 0;
    bit mon_en = 1;
    logic prev_wr = 1, prev_rd = 1, prev_cs = 1, prev_busy = 0;
    logic [7:0] cur_addr = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] acc(input bit r, input logic [7:0] a, input logic [7:0] d);
        return {15'd0, r, a, d};
    endfunction

    task automatic push_obs(input logic [31:0] o);
        if (exp_acc.size() == 0) chk("unexp_acc", o, 32'hFFFF_FFFF);
        else                     chk("access", o, exp_acc.pop_front());
    endtask

    // Bus monitor: decodes strobe edges into accesses, tracks timing facts.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!wr && prev_wr) begin
                if (!a_d) cur_addr = ad_out;
                else      push_obs(acc(1'b0, cur_addr, ad_out));
            end
            if (!rd && prev_rd) push_obs(acc(1'b1, cur_addr, ad_in));
            if (rd_valid) begin
                rdv_cnt++;
                if (exp_rd.size() == 0) chk("unexp_rdv", 32'({rd_idx, rd_data}), 32'hFFFF_FFFF);
                else                    chk("rd_ret", 32'({rd_idx, rd_data}), exp_rd.pop_front());
            end
        end
        if (!cs && prev_cs && !a_d) aset_q.push_back(cyc);
        if (!wr) wr_len++;
        else if (!prev_wr) begin
            if (wr_len != TP) wr_bad++;
            wr_len = 0;
        end
        if (!rd && ad_oe) oe_viol++;
        if (!cs) cs_low++;
        if (ready) begin ready_cnt++; ready_q.push_back(cyc); end
        if (busy && !prev_busy) busy_rise = cyc;
        if (!busy && prev_busy) busy_fall = cyc;
        prev_wr = wr; prev_rd = rd; prev_cs = cs; prev_busy = busy;
    end

    // m bits: 0 init,1 stop_ring,2 timer,3 hora,4 fecha,5 read
    task automatic pulse(input logic [5:0] m);
        @(posedge clk); #1;
        {req_read, req_fecha, req_hora, req_timer, req_stop_ring, req_init} = m;
        req_cyc = cyc;
        @(posedge clk); #1;
        {req_read, req_fecha, req_hora, req_timer, req_stop_ring, req_init} = 6'd0;
    endtask

    task automatic wait_ready(input int target, input int budget);
        for (int i = 0; i < budget && ready_cnt < target; i++) @(posedge clk);
        #1;
        chk("ready_count", ready_cnt, target);
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -9999;
    endfunction

    initial begin
        int r0, rc, csl;
        logic [7:0] ra [0:8];
        ra = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

        // Reset values
        #12;
        chk("rst_strobes", {a_d, cs, rd, wr, ad_oe, busy, ready, rd_valid}, 8'b1111_0000);
        chk("rst_bus", {ad_out, wr_sel, rd_data, rd_idx}, 32'd0);
        @(posedge clk); #1; rst = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("idle_no_cs", cs_low, 0);
        chk("idle_no_ready", ready_cnt, 0);

        // hora write
        aset_q.delete(); ready_q.delete();
        exp_acc.push_back(acc(0, 8'h21, 8'h45));
        exp_acc.push_back(acc(0, 8'h22, 8'h30));
        exp_acc.push_back(acc(0, 8'h23, 8'h12));
        exp_acc.push_back(acc(0, 8'hF1, 8'hF1));
        rc = ready_cnt;
        pulse(6'b001000);
        r0 = req_cyc;
        wait_ready(rc + 1, 200);
        repeat (3) @(posedge clk);
        chk("hora_nacc", aset_q.size(), 4);
        chk("hora_first_aset", qget(aset_q, 0) - r0, 2);
        for (int i = 1; i < 4; i++) chk("hora_acc_len", qget(aset_q, i) - qget(aset_q, i - 1), 8 * TP);
        chk("hora_ready_cyc", qget(ready_q, 0) - r0, 66);
        chk("hora_busy_rise", busy_rise - r0, 2);
        chk("hora_busy_fall", busy_fall - r0, 66);
        chk("hora_wr_len", wr_bad, 0);

        // read-all
        exp_acc.push_back(acc(0, 8'hF0, 8'hF0));
        for (int i = 0; i < 9; i++) begin
            exp_acc.push_back(acc(1, ra[i], ra[i] + 8'd1));
            exp_rd.push_back(32'({4'(8 - i), ra[i] + 8'd1}));
        end
        rc = ready_cnt; rdv_cnt = 0;
        pulse(6'b100000);
        wait_ready(rc + 1, 400);
        repeat (3) @(posedge clk);
        chk("read_rdv_cnt", rdv_cnt, 9);
        chk("read_rd_oe", oe_viol, 0);
        chk("read_exp_left", exp_rd.size(), 0);

        // fecha + stop_ring together: stop_ring first
        aset_q.delete(); ready_q.delete();
        exp_acc.push_back(acc(0, 8'h00, 8'h00));
        exp_acc.push_back(acc(0, 8'h24, 8'h15));
        exp_acc.push_back(acc(0, 8'h25, 8'h06));
        exp_acc.push_back(acc(0, 8'h26, 8'h24));
        exp_acc.push_back(acc(0, 8'hF1, 8'hF1));
        rc = ready_cnt;
        pulse(6'b010010);
        r0 = req_cyc;
        wait_ready(rc + 2, 300);
        repeat (3) @(posedge clk);
        chk("pri_nacc", aset_q.size(), 5);
        chk("pri_ready0", qget(ready_q, 0) - r0, 18);
        chk("pri_aset1", qget(aset_q, 1) - r0, 19);
        chk("pri_ready1", qget(ready_q, 1) - r0, 83);

        // stop_ring re-requested while running: runs twice
        ready_q.delete();
        exp_acc.push_back(acc(0, 8'h00, 8'h00));
        exp_acc.push_back(acc(0, 8'h00, 8'h00));
        rc = ready_cnt;
        pulse(6'b000010);
        r0 = req_cyc;
        repeat (3) @(posedge clk);
        pulse(6'b000010);
        wait_ready(rc + 2, 200);
        chk("rerun_ready1", qget(ready_q, 1) - r0, 35);
        chk("wr_len_all", wr_bad, 0);
        chk("acc_drained", exp_acc.size(), 0);

        // reset during D_STB of a timer write, with stop_ring pending
        mon_en = 0;
        rc = ready_cnt;
        pulse(6'b000100);
        pulse(6'b000010);
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                if (!cs && a_d && !wr) seen = 1;
            end
            chk("dstb_seen", 32'(seen), 1);
        end
        #2 rst = 1'b0;
        #1;
        chk("arst_strobes", {cs, wr, rd, a_d, ad_oe, busy}, 6'b111100);
        chk("arst_ad_out", ad_out, 8'h00);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        csl = cs_low;
        repeat (200) @(posedge clk);
        #1;
        chk("post_rst_no_cs", cs_low - csl, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_ready", ready_cnt, rc);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
